stepper_pulse_gen: RTL and testbench



---
 rtl/stepper_pulse_gen_pkg.sv | 21 ++
 rtl/stepper_pulse_gen_dda.sv | 55 +++++
 rtl/stepper_pulse_gen.sv | 152 +++++++++++++++
 tb/tb_stepper_pulse_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pulse_gen_pkg.sv
// Shared types and default constants for the stepper pulse generator.
package stepper_pulse_gen_pkg;

  localparam int unsigned DEF_SIM_PERIOD  = 500_000;
  localparam int unsigned DEF_POS_W       = 16;
  localparam int unsigned DEF_PULSE_HIGH  = 100;
  localparam int unsigned DEF_PULSE_LOW   = 100;
  localparam int unsigned DEF_DIR_SETUP   = 250;

  // DDA accumulator width and the width of the pulse-phase timer.
  localparam int unsigned ACC_W = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    DIR_SETUP,
    PULSE_HIGH,
    PULSE_LOW
  } pulse_state_e;

endpackage

// File: rtl/stepper_pulse_gen_dda.sv
// DDA rate generator: spreads abs_delta step tokens evenly over one window.
module dda_rate_gen
  import stepper_pulse_gen_pkg::*;
#(
  parameter int unsigned SIM_PERIOD = DEF_SIM_PERIOD,
  parameter int unsigned ABS_W      = DEF_POS_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [ABS_W-1:0] abs_delta,
  input  logic             consume,
  output logic [ABS_W-1:0] pending
);

  logic [ABS_W-1:0] abs_q;
  logic [ABS_W-1:0] generated;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum_c;
  logic             active_c;
  logic             token_c;

  // One accumulation step; a token falls out each time the sum crosses the period.
  always_comb begin
    active_c  = (generated < abs_q);
    acc_sum_c = acc + ACC_W'(abs_q);
    token_c   = active_c && (acc_sum_c >= ACC_W'(SIM_PERIOD));
  end

  // Window restart, accumulator and token bookkeeping; start discards leftovers.
  always_ff @(posedge clock) begin
    if (reset) begin
      abs_q     <= '0;
      generated <= '0;
      acc       <= '0;
      pending   <= '0;
    end else if (start) begin
      abs_q     <= abs_delta;
      generated <= '0;
      acc       <= '0;
      pending   <= '0;
    end else begin
      if (active_c) begin
        if (token_c) begin
          acc       <= acc_sum_c - ACC_W'(SIM_PERIOD);
          generated <= generated + ABS_W'(1);
        end else begin
          acc <= acc_sum_c;
        end
      end
      pending <= pending + ABS_W'(token_c) - ABS_W'(consume);
    end
  end

endmodule

// File: rtl/stepper_pulse_gen.sv
// Turns per-window delta_steps into evenly spaced STEP/DIR pulses and tracks emitted position.
module stepper_pulse_gen
  import stepper_pulse_gen_pkg::*;
#(
  parameter int unsigned simPeriod          = DEF_SIM_PERIOD,
  parameter int unsigned fixedPointBaseBits = DEF_POS_W,
  parameter int unsigned pulseHighCycles    = DEF_PULSE_HIGH,
  parameter int unsigned pulseLowCycles     = DEF_PULSE_LOW,
  parameter int unsigned dirSetupCycles     = DEF_DIR_SETUP
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 sync_sim_clock,
  input  logic signed [fixedPointBaseBits-1:0] delta_steps,
  output logic                                 step,
  output logic                                 dir,
  output logic signed [fixedPointBaseBits-1:0] motor_pos,
  output logic                                 busy,
  output logic                                 overrun
);

  localparam int unsigned POS_W = fixedPointBaseBits;
  localparam int unsigned ABS_W = POS_W + 1;
  // The IDLE decision cycle is the last low cycle, so PULSE_LOW itself runs one short.
  localparam int unsigned LOW_LOAD = (pulseLowCycles > 1) ? (pulseLowCycles - 2) : 0;

  pulse_state_e            state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    step_n, dir_n;
  logic signed [POS_W-1:0] pos_n;
  logic                    fire_c;
  logic                    consume_c;
  logic                    sync_prev;
  logic                    win_dir;
  logic                    edge_c;
  logic signed [ABS_W-1:0] delta_ext_c;
  logic [ABS_W-1:0]        abs_delta_c;
  logic [ABS_W-1:0]        pending;

  // Window edge and magnitude of the sampled delta (|-2^(N-1)| still fits in N+1 bits).
  always_comb begin
    edge_c      = sync_sim_clock && !sync_prev;
    delta_ext_c = ABS_W'(delta_steps);
    abs_delta_c = delta_ext_c[ABS_W-1] ? $unsigned(-delta_ext_c) : $unsigned(delta_ext_c);
  end

  dda_rate_gen #(
    .SIM_PERIOD (simPeriod),
    .ABS_W      (ABS_W)
  ) u_dda (
    .clock     (clock),
    .reset     (reset),
    .start     (edge_c),
    .abs_delta (abs_delta_c),
    .consume   (consume_c),
    .pending   (pending)
  );

  // Pulse FSM next-state and registered-output values.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    step_n    = step;
    dir_n     = dir;
    pos_n     = motor_pos;
    fire_c    = 1'b0;
    consume_c = 1'b0;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          if (dir != win_dir) begin
            state_n = DIR_SETUP;
            dir_n   = win_dir;
            cnt_n   = CNT_W'(dirSetupCycles - 1);
          end else begin
            fire_c = 1'b1;
          end
        end
      end
      DIR_SETUP: begin
        if (cnt == '0) begin
          // A new window may have dropped the token or flipped direction meanwhile.
          if ((pending != '0) && (dir == win_dir)) begin
            fire_c = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      PULSE_HIGH: begin
        if (cnt == '0) begin
          step_n = 1'b0;
          if (pulseLowCycles > 1) begin
            state_n = PULSE_LOW;
            cnt_n   = CNT_W'(LOW_LOAD);
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      PULSE_LOW: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (fire_c) begin
      state_n   = PULSE_HIGH;
      step_n    = 1'b1;
      consume_c = 1'b1;
      cnt_n     = CNT_W'(pulseHighCycles - 1);
      pos_n     = dir ? (motor_pos + POS_W'(1)) : (motor_pos - POS_W'(1));
    end
  end

  // State, outputs, window latch and sticky overrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      step      <= 1'b0;
      dir       <= 1'b0;
      motor_pos <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      sync_prev <= 1'b0;
      win_dir   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      step      <= step_n;
      dir       <= dir_n;
      motor_pos <= pos_n;
      busy      <= (state != IDLE) || (pending != '0);
      sync_prev <= sync_sim_clock;
      if (edge_c) begin
        win_dir <= !delta_steps[POS_W-1];
        if ((pending - ABS_W'(consume_c)) != '0) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Self-checking bench for stepper_pulse_gen with a window-level position model.
module tb_stepper_pulse_gen;

  localparam int SIM_P = 1000;
  localparam int PH    = 10;
  localparam int PL    = 10;
  localparam int DS    = 25;
  localparam int TICK  = 1002;
  localparam int MAX_PER_WIN = SIM_P / (PH + PL);

  logic               clock = 1'b0;
  logic               reset;
  logic               sync_sim_clock;
  logic signed [15:0] delta_steps;
  logic               step;
  logic               dir;
  logic signed [15:0] motor_pos;
  logic               busy;
  logic               overrun;

  int tests = 0;
  int fails = 0;

  stepper_pulse_gen #(
    .simPeriod          (SIM_P),
    .fixedPointBaseBits (16),
    .pulseHighCycles    (PH),
    .pulseLowCycles     (PL),
    .dirSetupCycles     (DS)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sync_sim_clock (sync_sim_clock),
    .delta_steps    (delta_steps),
    .step           (step),
    .dir            (dir),
    .motor_pos      (motor_pos),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clock = ~clock;

  // Pin-level observer: counts pulses and timing violations seen on step/dir.
  int   cyc = 0;
  int   rises = 0;
  int   high_bad = 0;
  int   low_bad = 0;
  int   setup_bad = 0;
  int   dir_bad = 0;
  int   dir_changes = 0;
  int   last_rise = -100000;
  int   last_fall = -100000;
  int   last_dir_chg = -100000;
  logic dir_chg_since = 1'b0;
  logic prev_step = 1'b0;
  logic prev_dir = 1'b0;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (step === 1'b1 && prev_step === 1'b0) begin
      rises = rises + 1;
      if (cyc - last_fall < PL) low_bad = low_bad + 1;
      if (dir_chg_since && (cyc - last_dir_chg < DS)) setup_bad = setup_bad + 1;
      dir_chg_since = 1'b0;
      last_rise = cyc;
    end
    if (step === 1'b0 && prev_step === 1'b1) begin
      if (cyc - last_rise != PH) high_bad = high_bad + 1;
      last_fall = cyc;
    end
    if (dir !== prev_dir) begin
      dir_changes = dir_changes + 1;
      if (step === 1'b1 || prev_step === 1'b1 || (cyc - last_fall < PL)) dir_bad = dir_bad + 1;
      last_dir_chg = cyc;
      dir_chg_since = 1'b1;
    end
    prev_step = step;
    prev_dir  = dir;
  end

  // Raise the tick and return a few cycles into the new window.
  task automatic tick_start(input int d);
    @(negedge clock);
    delta_steps    = 16'(d);
    sync_sim_clock = 1'b1;
    repeat (3) @(negedge clock);
    sync_sim_clock = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  // Finish out the window so ticks are TICK cycles apart.
  task automatic tick_rest();
    repeat (TICK - 7) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sync_sim_clock = 1'b0;
    delta_steps = '0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tests++; if (step !== 1'b0) begin fails++; $display("FAIL reset_step: got %b expected 0", step); end
    tests++; if (dir !== 1'b0) begin fails++; $display("FAIL reset_dir: got %b expected 0", dir); end
    tests++; if (motor_pos !== 16'sd0) begin fails++; $display("FAIL reset_pos: got %0d expected 0", motor_pos); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_zero_windows();
    int r0 = rises;
    for (int w = 0; w < 3; w++) begin
      tick_start(0);
      tick_rest();
    end
    tests++; if (rises - r0 !== 0) begin fails++; $display("FAIL zero_pulses: got %0d expected 0", rises - r0); end
    tests++; if (dir !== 1'b0) begin fails++; $display("FAIL zero_dir: got %b expected 0", dir); end
    tests++; if (motor_pos !== 16'sd0) begin fails++; $display("FAIL zero_pos: got %0d expected 0", motor_pos); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy: got %b expected 0", busy); end
  endtask

  task automatic test_plus4();
    int r0 = rises;
    int d0 = dir_changes;
    int h0 = high_bad;
    int s0 = setup_bad;
    tick_start(4);
    tick_rest();
    tick_start(0);
    tests++; if (rises - r0 !== 4) begin fails++; $display("FAIL plus4_pulses: got %0d expected 4", rises - r0); end
    tests++; if (dir_changes - d0 !== 1) begin fails++; $display("FAIL plus4_dir_changes: got %0d expected 1", dir_changes - d0); end
    tests++; if (dir !== 1'b1) begin fails++; $display("FAIL plus4_dir: got %b expected 1", dir); end
    tests++; if (setup_bad - s0 !== 0) begin fails++; $display("FAIL plus4_setup: got %0d short setups expected 0", setup_bad - s0); end
    tests++; if (high_bad - h0 !== 0) begin fails++; $display("FAIL plus4_high_width: got %0d bad widths expected 0", high_bad - h0); end
    tests++; if (motor_pos !== 16'sd4) begin fails++; $display("FAIL plus4_pos: got %0d expected 4", motor_pos); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL plus4_overrun: got %b expected 0", overrun); end
    tick_rest();
  endtask

  task automatic test_minus3();
    int r0 = rises;
    int b0 = dir_bad;
    int s0 = setup_bad;
    tick_start(-3);
    tick_rest();
    tick_start(0);
    tests++; if (rises - r0 !== 3) begin fails++; $display("FAIL minus3_pulses: got %0d expected 3", rises - r0); end
    tests++; if (dir !== 1'b0) begin fails++; $display("FAIL minus3_dir: got %b expected 0", dir); end
    tests++; if (dir_bad - b0 !== 0) begin fails++; $display("FAIL minus3_dir_timing: got %0d bad changes expected 0", dir_bad - b0); end
    tests++; if (setup_bad - s0 !== 0) begin fails++; $display("FAIL minus3_setup: got %0d short setups expected 0", setup_bad - s0); end
    tests++; if (motor_pos !== 16'sd1) begin fails++; $display("FAIL minus3_pos: got %0d expected 1", motor_pos); end
    tick_rest();
  endtask

  task automatic test_max_rate();
    int r0 = rises;
    int h0 = high_bad;
    int l0 = low_bad;
    int p0 = int'(motor_pos);
    tick_start(5);
    tick_rest();
    tick_start(0);
    tests++; if (rises - r0 !== 5) begin fails++; $display("FAIL realign_pulses: got %0d expected 5", rises - r0); end
    tick_rest();
    r0 = rises;
    tick_start(MAX_PER_WIN);
    tick_rest();
    tick_start(0);
    tests++; if (rises - r0 !== MAX_PER_WIN) begin fails++; $display("FAIL maxrate_pulses: got %0d expected %0d", rises - r0, MAX_PER_WIN); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL maxrate_overrun: got %b expected 0", overrun); end
    tests++; if (motor_pos !== 16'(p0 + 5 + MAX_PER_WIN)) begin fails++; $display("FAIL maxrate_pos: got %0d expected %0d", motor_pos, p0 + 5 + MAX_PER_WIN); end
    tests++; if (high_bad - h0 !== 0) begin fails++; $display("FAIL maxrate_high_width: got %0d bad widths expected 0", high_bad - h0); end
    tests++; if (low_bad - l0 !== 0) begin fails++; $display("FAIL maxrate_low_width: got %0d short lows expected 0", low_bad - l0); end
    tick_rest();
  endtask

  task automatic test_random_windows();
    int model_pos = int'(motor_pos);
    int prev_d = 0;
    int r0 = rises;
    int h0 = high_bad;
    int b0 = dir_bad;
    int s0 = setup_bad;
    for (int w = 0; w <= 8; w++) begin
      int d = 0;
      if (w < 8 && $urandom_range(0, 7) != 0) begin
        d = int'($urandom_range(2, 40));
        if ($urandom_range(0, 1) == 1) d = -d;
      end
      tick_start(d);
      if (w > 0) begin
        int mag = (prev_d < 0) ? -prev_d : prev_d;
        tests++; if (rises - r0 !== mag) begin fails++; $display("FAIL rand_pulses[%0d]: delta %0d got %0d expected %0d", w - 1, prev_d, rises - r0, mag); end
        tests++; if (motor_pos !== 16'(model_pos)) begin fails++; $display("FAIL rand_pos[%0d]: got %0d expected %0d", w - 1, motor_pos, model_pos); end
      end
      r0 = rises;
      model_pos = model_pos + d;
      prev_d = d;
      tick_rest();
    end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rand_overrun: got %b expected 0", overrun); end
    tests++; if (high_bad - h0 + dir_bad - b0 + setup_bad - s0 !== 0) begin fails++; $display("FAIL rand_timing: got %0d violations expected 0", high_bad - h0 + dir_bad - b0 + setup_bad - s0); end
  endtask

  task automatic test_overrun();
    int r0 = rises;
    int p0 = int'(motor_pos);
    tick_start(60);
    tick_rest();
    tick_start(0);
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    tests++; if (rises - r0 > MAX_PER_WIN) begin fails++; $display("FAIL overrun_pulses: got %0d expected at most %0d", rises - r0, MAX_PER_WIN); end
    tests++; if (motor_pos !== 16'(p0 + rises - r0)) begin fails++; $display("FAIL overrun_pos: got %0d expected %0d", motor_pos, p0 + rises - r0); end
    tick_rest();
    tick_start(0);
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    tick_rest();
  endtask

  task automatic test_reset_mid_pulse();
    int waited = 0;
    int r0;
    tick_start(10);
    while (step !== 1'b1 && waited < 1200) begin
      @(negedge clock);
      waited++;
    end
    tests++; if (step !== 1'b1) begin fails++; $display("FAIL midreset_wait: got step %b expected 1 within 1200 cycles", step); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    tests++; if (step !== 1'b0) begin fails++; $display("FAIL midreset_step: got %b expected 0", step); end
    tests++; if (motor_pos !== 16'sd0) begin fails++; $display("FAIL midreset_pos: got %0d expected 0", motor_pos); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL midreset_overrun: got %b expected 0", overrun); end
    tests++; if (dir !== 1'b0) begin fails++; $display("FAIL midreset_dir: got %b expected 0", dir); end
    reset = 1'b0;
    @(negedge clock);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    r0 = rises;
    repeat (1500) @(negedge clock);
    tests++; if (rises - r0 !== 0) begin fails++; $display("FAIL midreset_quiet: got %0d pulses expected 0", rises - r0); end
    r0 = rises;
    tick_start(3);
    tick_rest();
    tick_start(0);
    tests++; if (rises - r0 !== 3) begin fails++; $display("FAIL midreset_resume_pulses: got %0d expected 3", rises - r0); end
    tests++; if (motor_pos !== 16'sd3) begin fails++; $display("FAIL midreset_resume_pos: got %0d expected 3", motor_pos); end
    tick_rest();
  endtask

  initial begin
    test_reset();
    test_zero_windows();
    test_plus4();
    test_minus3();
    test_max_rate();
    test_random_windows();
    test_overrun();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
